// File: rtl/sync_fifo.sv
// Synchronous byte FIFO with occupancy count, almost-full/almost-empty thresholds
// and sticky overflow/underflow flags. One clock, asynchronous active-low reset.
module sync_fifo #(
  parameter int DATA_W   = 8,
  parameter int DEPTH    = 8,
  parameter int ADDR_W   = 3,
  parameter int AF_LEVEL = 6,
  parameter int AE_LEVEL = 2
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  input  logic              clr_err,
  output logic [DATA_W-1:0] dout,
  output logic              empty,
  output logic              full,
  output logic              almost_empty,
  output logic              almost_full,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              underflow
);

  localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] AF_CNT    = (ADDR_W+1)'(AF_LEVEL);
  localparam logic [ADDR_W:0] AE_CNT    = (ADDR_W+1)'(AE_LEVEL);

  logic [DATA_W-1:0] mem [DEPTH];

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q,  count_d;
  logic [DATA_W-1:0] dout_q,   dout_d;
  logic              ovf_q,    ovf_d;
  logic              udf_q,    udf_d;

  logic pop_ok;
  logic push_ok;

  // Flags decode from the registered count, so they reflect the previous edge.
  assign empty        = (count_q == '0);
  assign full         = (count_q == DEPTH_CNT);
  assign almost_empty = (count_q <= AE_CNT);
  assign almost_full  = (count_q >= AF_CNT);

  // A push into a full FIFO is still accepted when a pop frees a slot on the same edge.
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);

  always_comb begin
    // NOTE: every signal driven here gets a default first so no latch is inferred.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    dout_d   = dout_q;

    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
      dout_d   = mem[rd_ptr_q];
    end

    unique case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    // A fresh error on the same edge as clr_err keeps the flag set.
    ovf_d = (ovf_q && !clr_err) || (push && !push_ok);
    udf_d = (udf_q && !clr_err) || (pop && !pop_ok);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      dout_q   <= '0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values.
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      dout_q   <= dout_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  // NOTE: storage has no reset; the pointers and count alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_q] <= din;
  end

  assign dout      = dout_q;
  assign count     = count_q;
  assign overflow  = ovf_q;
  assign underflow = udf_q;

endmodule

// File: tb/tb_sync_fifo.sv
// Self-checking bench for sync_fifo: directed scenarios plus random traffic,
// compared against a queue-based reference model.
module tb_sync_fifo;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 8;
  localparam int ADDR_W = 3;
  localparam int AF_LVL = 6;
  localparam int AE_LVL = 2;

  logic              clk = 1'b0;
  logic              rstn;
  logic              push;
  logic              pop;
  logic [DATA_W-1:0] din;
  logic              clr_err;
  logic [DATA_W-1:0] dout;
  logic              empty;
  logic              full;
  logic              almost_empty;
  logic              almost_full;
  logic [ADDR_W:0]   count;
  logic              overflow;
  logic              underflow;

  sync_fifo #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W),
    .AF_LEVEL(AF_LVL), .AE_LEVEL(AE_LVL)
  ) dut (
    .clk(clk), .rstn(rstn), .push(push), .pop(pop), .din(din), .clr_err(clr_err),
    .dout(dout), .empty(empty), .full(full), .almost_empty(almost_empty),
    .almost_full(almost_full), .count(count), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  // Reference model: a queue of stored bytes plus the last popped byte and error flags.
  logic [DATA_W-1:0] model_q [$];
  logic [DATA_W-1:0] dout_m;
  bit                ovf_m;
  bit                udf_m;

  int n_vec  = 0;
  int n_miss = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_miss++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    int sz;
    sz = model_q.size();
    check({tag, ":count"},        32'(count),        32'(sz));
    check({tag, ":empty"},        32'(empty),        32'(sz == 0));
    check({tag, ":full"},         32'(full),         32'(sz == DEPTH));
    check({tag, ":almost_empty"}, 32'(almost_empty), 32'(sz <= AE_LVL));
    check({tag, ":almost_full"},  32'(almost_full),  32'(sz >= AF_LVL));
    check({tag, ":dout"},         32'(dout),         32'(dout_m));
    check({tag, ":overflow"},     32'(overflow),     32'(ovf_m));
    check({tag, ":underflow"},    32'(underflow),    32'(udf_m));
  endtask

  task automatic model_reset();
    model_q.delete();
    dout_m = '0;
    ovf_m  = 1'b0;
    udf_m  = 1'b0;
  endtask

  // Apply one cycle of inputs, advance the model by the FIFO rules, then compare.
  task automatic step(input bit p, input bit r, input logic [DATA_W-1:0] d,
                      input bit c, input string tag);
    bit pop_acc;
    bit push_acc;
    push = p; pop = r; din = d; clr_err = c;
    @(posedge clk);
    pop_acc  = r && (model_q.size() > 0);
    push_acc = p && ((model_q.size() < DEPTH) || pop_acc);
    if (pop_acc)  dout_m = model_q.pop_front();
    if (push_acc) model_q.push_back(d);
    ovf_m = (ovf_m && !c) || (p && !push_acc);
    udf_m = (udf_m && !c) || (r && !pop_acc);
    #1;
    check_all(tag);
    push = 1'b0; pop = 1'b0; clr_err = 1'b0;
  endtask

  initial begin
    logic [DATA_W-1:0] seq4 [4];
    logic [DATA_W-1:0] v;
    seq4[0] = 8'h11; seq4[1] = 8'h22; seq4[2] = 8'h33; seq4[3] = 8'h44;

    rstn = 1'b0; push = 1'b0; pop = 1'b0; din = '0; clr_err = 1'b0;
    model_reset();
    #2;
    check_all("reset");
    check("reset_dout_zero", 32'(dout), 32'h00);
    @(negedge clk);
    rstn = 1'b1;

    // FIFO ordering with a short burst
    for (int i = 0; i < 4; i++) begin
      step(1, 0, seq4[i], 0, "push4");
      check("push4_count", 32'(count), 32'(i + 1));
    end
    for (int i = 0; i < 4; i++) begin
      step(0, 1, '0, 0, "pop4");
      check("pop4_order", 32'(dout), 32'(seq4[i]));
    end
    check("pop4_empty", 32'(empty), 32'd1);

    // Fill, overflow, drain
    for (int i = 1; i <= 8; i++) step(1, 0, 8'(i), 0, "fill");
    check("fill_full", 32'(full), 32'd1);
    step(1, 0, 8'h09, 0, "overflow");
    check("overflow_flag", 32'(overflow), 32'd1);
    check("overflow_count", 32'(count), 32'd8);
    for (int i = 1; i <= 8; i++) begin
      step(0, 1, '0, 0, "drain");
      check("drain_order", 32'(dout), 32'(i));
    end
    step(0, 0, '0, 1, "clr_ovf");

    // Simultaneous push and pop while full
    for (int i = 1; i <= 8; i++) step(1, 0, 8'(i), 0, "refill");
    step(1, 1, 8'hAA, 0, "full_pushpop");
    check("full_pushpop_dout", 32'(dout), 32'h01);
    check("full_pushpop_full", 32'(full), 32'd1);
    for (int i = 2; i <= 8; i++) step(0, 1, '0, 0, "drain_after");
    step(0, 1, '0, 0, "drain_last");
    check("drain_last_aa", 32'(dout), 32'hAA);

    // Underflow and simultaneous push/pop while empty
    step(0, 1, '0, 0, "underflow");
    check("underflow_flag", 32'(underflow), 32'd1);
    check("underflow_hold", 32'(dout), 32'hAA);
    step(1, 1, 8'hBB, 0, "empty_pushpop");
    check("empty_pushpop_count", 32'(count), 32'd1);
    check("empty_pushpop_nowt", 32'(dout), 32'hAA);
    step(0, 1, '0, 0, "pop_bb");
    check("pop_bb_dout", 32'(dout), 32'hBB);
    step(0, 1, '0, 1, "clr_vs_new_err");
    check("clr_new_err_wins", 32'(underflow), 32'd1);
    step(0, 0, '0, 1, "clr_err");
    check("clr_err_udf", 32'(underflow), 32'd0);

    // Pointer wrap-around with distinct data each round
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 6; i++) step(1, 0, 8'(16 * r + i + 8'h40), 0, "wrap_push");
      for (int i = 0; i < 6; i++) begin
        step(0, 1, '0, 0, "wrap_pop");
        check("wrap_order", 32'(dout), 32'(16 * r + i + 8'h40));
      end
    end
    check("wrap_count0", 32'(count), 32'd0);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      v = 8'($urandom);
      step(1'($urandom_range(0, 99) < 55), 1'($urandom_range(0, 99) < 45), v,
           1'($urandom_range(0, 99) < 5), "rand");
    end

    // Asynchronous reset in the middle of a burst
    for (int i = 0; i < 5; i++) step(1, 0, 8'(8'hC0 + i), 0, "pre_rst");
    #2;
    rstn = 1'b0;
    #1;
    check("async_rst_count", 32'(count), 32'd0);
    check("async_rst_empty", 32'(empty), 32'd1);
    model_reset();
    check_all("async_rst");
    #1;
    rstn = 1'b1;
    step(1, 0, 8'h5A, 0, "post_rst_push");
    step(1, 0, 8'h5B, 0, "post_rst_push");
    step(0, 1, '0, 0, "post_rst_pop");
    check("post_rst_first", 32'(dout), 32'h5A);
    step(0, 1, '0, 0, "post_rst_pop");
    check("post_rst_second", 32'(dout), 32'h5B);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
